// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: 40x30 tile map to 12-bit VGA colour with sync delayed to match.
// Optional SNAKE_BORDER_EN forces the outer ring of tiles to white.
module snake_tile_renderer #(
  parameter int TILES_X    = 40,
  parameter int TILES_Y    = 30,
  parameter int TILE_SHIFT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       video_on,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       clear_req,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [1:0] wr_cell,
  output logic       HS,
  output logic       VS,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B,
  output logic       frame_start
);
  localparam int NT = TILES_X * TILES_Y;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [10:0] clr_addr_q, clr_addr_d, wa, ra, wr_addr;
  logic        we, von1_q, hs1_q, vs1_q, hs_q, vs_q, fs_q;
  logic [1:0]  wd, rd_q, code;
  logic [9:0]  ht, vt;
  logic [11:0] rgb_q, rgb_d;
  logic [1:0]  mem [0:NT-1];
  function automatic logic [10:0] tile_addr(input logic [9:0] row, input logic [9:0] col);
    return ({1'b0, row} << 5) + ({1'b0, row} << 3) + {1'b0, col};
  endfunction
  assign ht       = h_count >> TILE_SHIFT;
  assign vt       = v_count >> TILE_SHIFT;
  assign wr_addr  = tile_addr({5'b0, wr_y}, {4'b0, wr_x});
  assign ra       = video_on ? tile_addr(vt, ht) : 11'd0;
  assign wr_ready = state_q == IDLE;
  assign wd       = state_q == CLEAR ? 2'b00 : wr_cell;
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    we         = 1'b0;
    wa         = clr_addr_q;
    if (state_q == CLEAR) begin
      we         = 1'b1;
      clr_addr_d = clr_addr_q + 11'd1;
      state_d    = clr_addr_q == 11'(NT - 1) ? IDLE : CLEAR;
    end else begin
      we = wr_valid && wr_x < 6'(TILES_X) && wr_y < 5'(TILES_Y);
      wa = wr_addr;
    end
    if (clear_req) begin
      state_d    = CLEAR;
      clr_addr_d = 11'd0;
      we         = we && state_q == CLEAR;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= 11'd0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end
  // Nonblocking read of the written address yields the old data.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (pix_en) rd_q <= mem[ra];
  end
`ifdef SNAKE_BORDER_EN
  logic [9:0] tx1_q, ty1_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx1_q <= 10'd0;
      ty1_q <= 10'd0;
    end else if (pix_en) begin
      tx1_q <= ht;
      ty1_q <= vt;
    end
  end
  assign code = (tx1_q == 10'd0 || tx1_q == 10'(TILES_X - 1) ||
                 ty1_q == 10'd0 || ty1_q == 10'(TILES_Y - 1)) ? 2'd3 : rd_q;
`else
  assign code = rd_q;
`endif
  assign rgb_d = von1_q ? {{4{code[1]}}, {4{code[0]}}, {4{&code}}} : 12'h000;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      von1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      rgb_q  <= 12'h000;
      fs_q   <= 1'b0;
    end else begin
      fs_q <= pix_en && h_count == 10'd0 && v_count == 10'd0;
      if (pix_en) begin
        von1_q <= video_on;
        hs1_q  <= hs_in;
        vs1_q  <= vs_in;
        hs_q   <= hs1_q;
        vs_q   <= vs1_q;
        rgb_q  <= rgb_d;
      end
    end
  end
  assign {R, G, B}   = rgb_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign frame_start = fs_q;
endmodule
